// File: rtl/wrap_tracker.sv
// Tens/hundreds BCD tracker following an upstream ones-digit counter.
// Carry/borrow are inferred from the step code and the ones-digit change.
module wrap_tracker #(
  parameter bit HUND_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] step,
  input  logic [3:0] digit_in,
  input  logic       clear_flags,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       ovf,
  output logic       unf,
  output logic [1:0] blank
);

  logic [3:0] prev_q, prev_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] hund_q, hund_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic accept;
  logic up;
  logic dn;
  logic carry;
  logic borrow;
  logic ovf_set;
  logic unf_set;

  // Out-of-range ones digits are dropped entirely.
  assign accept = tick && (digit_in <= 4'd9);
  assign up     = (step == 2'b01) || (step == 2'b10);
  assign dn     = (step == 2'b11);
  assign carry  = accept && up && (digit_in < prev_q);
  assign borrow = accept && dn && (digit_in > prev_q);

  always_comb begin
    prev_d  = prev_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (accept) prev_d = digit_in;
    unique case (1'b1)
      carry: begin
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          if (!HUND_EN) begin
            ovf_set = 1'b1;
          end else if (hund_q == 4'd9) begin
            hund_d  = 4'd0;
            ovf_set = 1'b1;
          end else begin
            hund_d = hund_q + 4'd1;
          end
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end
      borrow: begin
        if (tens_q == 4'd0) begin
          tens_d = 4'd9;
          if (!HUND_EN) begin
            unf_set = 1'b1;
          end else if (hund_q == 4'd0) begin
            hund_d  = 4'd9;
            unf_set = 1'b1;
          end else begin
            hund_d = hund_q - 4'd1;
          end
        end else begin
          tens_d = tens_q - 4'd1;
        end
      end
      default: ;
    endcase
    if (!HUND_EN) hund_d = 4'd0;
    ovf_d = (ovf_q && !clear_flags) || ovf_set;
    unf_d = (unf_q && !clear_flags) || unf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 4'd0;
      tens_q <= 4'd0;
      hund_q <= 4'd0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      tens_q <= tens_d;
      hund_q <= hund_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_comb begin
    tens     = tens_q;
    hundreds = hund_q;
    ovf      = ovf_q;
    unf      = unf_q;
    blank[1] = (hund_q == 4'd0);
    blank[0] = (hund_q == 4'd0) && (tens_q == 4'd0);
  end

endmodule

// File: tb/tb_wrap_tracker.sv
// Directed bench for wrap_tracker: one instance with hundreds tracking,
// one without, both driven from the same stimulus.
module tb_wrap_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] step;
  logic [3:0] digit_in;
  logic       clear_flags;

  logic [3:0] tens0, hund0, tens1, hund1;
  logic       ovf0, unf0, ovf1, unf1;
  logic [1:0] blank0, blank1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wrap_tracker #(.HUND_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .step(step),
    .digit_in(digit_in), .clear_flags(clear_flags),
    .tens(tens0), .hundreds(hund0), .ovf(ovf0), .unf(unf0),
    .blank(blank0)
  );

  wrap_tracker #(.HUND_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .step(step),
    .digit_in(digit_in), .clear_flags(clear_flags),
    .tens(tens1), .hundreds(hund1), .ovf(ovf1), .unf(unf1),
    .blank(blank1)
  );

  task automatic cyc(input logic r, input logic t,
                     input logic [1:0] s, input logic [3:0] d,
                     input logic c);
    @(negedge clk);
    reset       = r;
    tick        = t;
    step        = s;
    digit_in    = d;
    clear_flags = c;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    tick        = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input int t, input int h,
                      input int o, input int u, input int b);
    chk({tag, ".h1.tens"}, int'(tens0), t);
    chk({tag, ".h1.hund"}, int'(hund0), h);
    chk({tag, ".h1.ovf"}, int'(ovf0), o);
    chk({tag, ".h1.unf"}, int'(unf0), u);
    chk({tag, ".h1.blank"}, int'(blank0), b);
  endtask

  task automatic chk1(input string tag, input int t,
                      input int o, input int u, input int b);
    chk({tag, ".h0.tens"}, int'(tens1), t);
    chk({tag, ".h0.hund"}, int'(hund1), 0);
    chk({tag, ".h0.ovf"}, int'(ovf1), o);
    chk({tag, ".h0.unf"}, int'(unf1), u);
    chk({tag, ".h0.blank"}, int'(blank1), b);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; step = 2'b00;
    digit_in = 4'd0; clear_flags = 1'b0;

    cyc(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
    chk0("reset", 0, 0, 0, 0, 3);
    chk1("reset", 0, 0, 0, 3);

    for (int i = 1; i <= 10; i++)
      cyc(1'b0, 1'b1, 2'b01, 4'(i % 10), 1'b0);
    chk0("count10", 1, 0, 0, 0, 2);
    chk1("count10", 1, 0, 0, 2);

    for (int i = 1; i <= 90; i++)
      cyc(1'b0, 1'b1, 2'b01, 4'(i % 10), 1'b0);
    chk0("count100", 0, 1, 0, 0, 0);
    chk1("count100", 0, 1, 0, 3);

    cyc(1'b0, 1'b1, 2'b11, 4'd9, 1'b0);
    chk0("borrow_h", 9, 0, 0, 0, 2);
    chk1("borrow_h", 9, 1, 1, 2);

    cyc(1'b0, 1'b0, 2'b11, 4'd3, 1'b0);
    chk0("notick", 9, 0, 0, 0, 2);

    cyc(1'b0, 1'b1, 2'b00, 4'd7, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 4'd5, 1'b0);
    chk0("hold", 9, 0, 0, 0, 2);
    cyc(1'b0, 1'b1, 2'b01, 4'd6, 1'b0);
    chk0("hold_next", 9, 0, 0, 0, 2);

    cyc(1'b0, 1'b1, 2'b11, 4'd12, 1'b0);
    chk0("bad_digit", 9, 0, 0, 0, 2);
    cyc(1'b0, 1'b1, 2'b01, 4'd7, 1'b0);
    chk0("bad_digit_prev", 9, 0, 0, 0, 2);

    cyc(1'b0, 1'b1, 2'b00, 4'd9, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 4'd0, 1'b1);
    chk0("reset_tick", 0, 0, 0, 0, 3);
    chk1("reset_tick", 0, 0, 0, 3);
    cyc(1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
    chk0("post_reset", 0, 0, 0, 0, 3);

    cyc(1'b0, 1'b1, 2'b11, 4'd9, 1'b0);
    chk0("unf_wrap", 9, 9, 0, 1, 0);
    chk1("unf_wrap", 9, 0, 1, 2);
    cyc(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
    chk0("unf_clear", 9, 9, 0, 0, 0);
    chk1("unf_clear", 9, 0, 0, 2);

    cyc(1'b0, 1'b1, 2'b10, 4'd1, 1'b0);
    chk0("ovf_wrap", 0, 0, 1, 0, 3);
    chk1("ovf_wrap", 0, 1, 0, 3);
    cyc(1'b0, 1'b1, 2'b11, 4'd9, 1'b0);
    chk0("unf_again", 9, 9, 1, 1, 0);
    chk1("unf_again", 9, 1, 1, 2);
    cyc(1'b0, 1'b1, 2'b01, 4'd0, 1'b1);
    chk0("set_wins", 0, 0, 1, 0, 3);
    chk1("set_wins", 0, 1, 0, 3);
    cyc(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
    chk0("ovf_clear", 0, 0, 0, 0, 3);
    chk1("ovf_clear", 0, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrap_tracker.md
WRAP_TRACKER -- requirements
Module: wrap_tracker

Interface
REQ-001 SHALL have parameter HUND_EN, default 1: 1 = track a hundreds digit; 0 = hundreds held at 0 and the range is 00..99.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port tick, input, 1: one-cycle strobe, high in the cycle the upstream ones-digit counter has just loaded a new value.
REQ-005 SHALL have port step, input, 2: step code applied at that update (00 hold, 01 +1, 10 +2, 11 -1).
REQ-006 SHALL have port digit_in, input, 4: new ones digit after the update, BCD 0..9.
REQ-007 SHALL have port clear_flags, input, 1: clears the sticky flags.
REQ-008 SHALL have port tens, output, 4: tens digit, BCD.
REQ-009 SHALL have port hundreds, output, 4: hundreds digit, BCD.
REQ-010 SHALL have port ovf, output, 1: sticky flag, count wrapped upward past the maximum.
REQ-011 SHALL have port unf, output, 1: sticky flag, count wrapped downward past 0.
REQ-012 SHALL have port blank, output, 2: leading-zero suppression mask (bit1 hundreds display, bit0 tens display), 1 = blank.

Function
REQ-013 SHALL hold an internal register prev_digit with the last accepted ones digit; it loads digit_in on every tick.
REQ-014 SHALL ignore step, digit_in and clear on non-tick cycles for digit state; nothing changes except via clear_flags.
REQ-015 SHALL detect carry on tick when step is 01 or 10 and digit_in < prev_digit (9->0 on +1; 8->0 or 9->1 on +2).
REQ-016 SHALL detect borrow on tick when step is 11 and digit_in > prev_digit (0->9).
REQ-017 SHALL detect neither carry nor borrow on tick with step 00, even if digit_in differs from prev_digit; prev_digit still loads.
REQ-018 On carry, SHALL increment tens in BCD; tens 9 -> 0 with carry into hundreds when HUND_EN=1; hundreds 9 -> 0.
REQ-019 On borrow, SHALL decrement tens in BCD; tens 0 -> 9 with borrow from hundreds when HUND_EN=1; hundreds 0 -> 9.
REQ-020 SHALL set ovf on carry out of the top tracked digit: hundreds 9->0 with HUND_EN=1, or tens 9->0 with HUND_EN=0.
REQ-021 SHALL set unf on borrow out of the top tracked digit: hundreds 0->9 with HUND_EN=1, or tens 0->9 with HUND_EN=0.
REQ-022 Digits SHALL always wrap modulo the range; they never saturate.
REQ-023 With HUND_EN=0, hundreds SHALL be constant 0 and blank[1] constant 1.
REQ-024 SHALL update all outputs one cycle after the tick edge: registered, no combinational path from inputs to outputs.
REQ-025 SHALL compute blank combinationally from registered digits only:
- blank[1] = (hundreds==0)
- blank[0] = (hundreds==0 && tens==0)
REQ-026 clear_flags SHALL zero ovf and unf next cycle; if a new overflow or underflow event occurs in the same cycle, set wins for that flag.
REQ-027 SHALL treat digit_in > 9 as a protocol violation: no digit update, prev_digit unchanged; checker-only condition.

Reset
REQ-028 On reset high at a clk edge, SHALL clear prev_digit, tens, hundreds, ovf and unf to 0, giving blank = 2'b11.
REQ-029 Reset SHALL take priority over tick and clear_flags in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard any pending carry or borrow; the first tick after release compares against prev_digit = 0.

Verification
REQ-031 Reset, then 10 ticks of step=01 with digit_in 1..9,0 -> tens=1, hundreds=0, blank=2'b10, ovf=0.
REQ-032 From 000, tick step=11 digit_in=9 -> tens=9, hundreds=9, unf=1; then clear_flags -> unf=0, digits unchanged.
REQ-033 From prev=9, tens=9, hundreds=9, tick step=10 digit_in=1 -> tens=0, hundreds=0, ovf=1; a tick with clear_flags and another ovf event keeps ovf=1.
REQ-034 HUND_EN=0: from tens=9, prev=9, tick step=01 digit_in=0 -> tens=0, ovf=1, hundreds=0, blank[1]=1.
REQ-035 Tick step=00 with digit_in=5 from prev=7 -> no tens change; next tick step=01 digit_in=6 -> no carry.
REQ-036 Reset asserted in the same cycle as a carry-producing tick -> all outputs 0, blank=2'b11 next cycle.
